vga_pixel_cmd_writer: RTL and testbench

- Consumes the 32-bit pixel-status word driven by the CPU-written Avalon PIO output register.
- Decodes the word as a drawing command and performs Avalon-MM master writes into the VGA framebuffer: single pixel, row fill, or full-screen clear.
- Returns a 32-bit status word, intended for an input PIO, so software can poll for completion.
- Sits between the pixel-status PIO and the framebuffer RAM/arbiter.

---
 rtl/vga_pixel_cmd_writer_if.sv | 27 ++
 rtl/vga_pixel_cmd_writer.sv | 155 +++++++++++++++
 tb/tb_vga_pixel_cmd_writer.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pixel_cmd_writer_if.sv
// Avalon-MM write-only master bus from the pixel command writer to the framebuffer.
// The master drives address/data/write; the slave answers with waitrequest.
interface vga_pixel_cmd_writer_if #(
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned COLOR_W = 8
) ();

  logic [ADDR_W-1:0]  fb_address;
  logic [COLOR_W-1:0] fb_writedata;
  logic               fb_write;
  logic               fb_waitrequest;

  modport master (
    output fb_address,
    output fb_writedata,
    output fb_write,
    input  fb_waitrequest
  );

  modport slave (
    input  fb_address,
    input  fb_writedata,
    input  fb_write,
    output fb_waitrequest
  );

endinterface

// File: rtl/vga_pixel_cmd_writer.sv
// Decodes the pixel-status PIO word into pixel / row-fill / clear commands and streams
// the resulting framebuffer writes over Avalon-MM, reporting progress on a status word.
module vga_pixel_cmd_writer #(
  parameter int unsigned H_RES   = 640,
  parameter int unsigned V_RES   = 480,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned COLOR_W = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [31:0]               cmd_in,
  vga_pixel_cmd_writer_if.master    fb,
  output logic [31:0]               status_out
);

  // One extra bit so a full-frame count never aliases to zero.
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(H_RES * V_RES);

  localparam logic [1:0] OP_PIXEL = 2'b00;
  localparam logic [1:0] OP_ROW   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  typedef enum logic [1:0] {StIdle, StSetup, StWrite, StDone} state_e;

  state_e             state_q, state_d;
  logic [31:0]        cmd_q, cmd_d;
  logic               last_toggle_q, last_toggle_d;
  logic               busy_q, busy_d;
  logic               done_toggle_q, done_toggle_d;
  logic               error_q, error_d;
  logic [15:0]        cmd_count_q, cmd_count_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic               write_q, write_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [1:0]  op;
  logic [31:0] x_ext;
  logic [31:0] y_ext;
  logic        in_range;
  logic        cmd_bad;
  logic        unused_cmd_bits;

  assign op       = cmd_q[28:27];
  assign x_ext    = {22'd0, cmd_q[17:8]};
  assign y_ext    = {23'd0, cmd_q[26:18]};
  assign in_range = (x_ext < H_RES) && (y_ext < V_RES);
  // Clear ignores x/y, so only pixel and row commands are range-checked.
  assign cmd_bad  = (op == OP_ILL) || ((op != OP_CLEAR) && !in_range);

  // Toggle and reserved bits are latched with the word but carry no meaning afterwards.
  assign unused_cmd_bits = ^cmd_q[31:29];

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    last_toggle_d = last_toggle_q;
    busy_d        = busy_q;
    done_toggle_d = done_toggle_q;
    error_d       = error_q;
    cmd_count_d   = cmd_count_q;
    addr_d        = addr_q;
    data_d        = data_q;
    write_d       = write_q;
    cnt_d         = cnt_q;

    case (state_q)
      StIdle: begin
        // Only the word present when we come back to idle is executed.
        if (cmd_in[31] != last_toggle_q) begin
          cmd_d         = cmd_in;
          last_toggle_d = cmd_in[31];
          busy_d        = 1'b1;
          state_d       = StSetup;
        end
      end

      StSetup: begin
        if (cmd_bad) begin
          error_d = 1'b1;
          state_d = StDone;
        end else begin
          error_d = 1'b0;
          addr_d  = (op == OP_CLEAR) ? '0 : ADDR_W'(y_ext * H_RES + x_ext);
          case (op)
            OP_PIXEL: cnt_d = CNT_W'(1);
            OP_ROW:   cnt_d = CNT_W'(H_RES - x_ext);
            default:  cnt_d = FRAME_PIX;
          endcase
          data_d  = COLOR_W'(cmd_q[7:0]);
          write_d = 1'b1;
          state_d = StWrite;
        end
      end

      StWrite: begin
        if (!fb.fb_waitrequest) begin
          if (cnt_q == CNT_W'(1)) begin
            write_d = 1'b0;
            state_d = StDone;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
            cnt_d  = cnt_q - CNT_W'(1);
          end
        end
      end

      StDone: begin
        busy_d        = 1'b0;
        done_toggle_d = ~done_toggle_q;
        cmd_count_d   = cmd_count_q + 16'd1;
        state_d       = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cmd_q         <= '0;
      last_toggle_q <= 1'b0;
      busy_q        <= 1'b0;
      done_toggle_q <= 1'b0;
      error_q       <= 1'b0;
      cmd_count_q   <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      write_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      last_toggle_q <= last_toggle_d;
      busy_q        <= busy_d;
      done_toggle_q <= done_toggle_d;
      error_q       <= error_d;
      cmd_count_q   <= cmd_count_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      write_q       <= write_d;
      cnt_q         <= cnt_d;
    end
  end

  assign fb.fb_address   = addr_q;
  assign fb.fb_writedata = data_q;
  assign fb.fb_write     = write_q;

  assign status_out = {cmd_count_q, 13'd0, error_q, done_toggle_q, busy_q};

endmodule

// File: tb/tb_vga_pixel_cmd_writer.sv
// Scoreboard bench for vga_pixel_cmd_writer on a reduced 40x30 frame so full clears stay short.
// Expected framebuffer writes are queued when a command is issued and popped as writes occur.
module tb_vga_pixel_cmd_writer;

  localparam int unsigned HR    = 40;
  localparam int unsigned VR    = 30;
  localparam int unsigned AW    = 11;
  localparam int unsigned CW    = 8;
  localparam int unsigned FRAME = HR * VR;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cmd_in = '0;
  logic [31:0] status_out;

  vga_pixel_cmd_writer_if #(.ADDR_W(AW), .COLOR_W(CW)) fb_if ();

  vga_pixel_cmd_writer #(
    .H_RES   (HR),
    .V_RES   (VR),
    .ADDR_W  (AW),
    .COLOR_W (CW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_in     (cmd_in),
    .fb         (fb_if),
    .status_out (status_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;

  logic [AW+CW-1:0] exp_q[$];
  logic             tog = 1'b0;
  logic             exp_done = 1'b0;
  logic             exp_err = 1'b0;
  logic [15:0]      exp_count = '0;

  logic             prev_stall = 1'b0;
  logic [AW-1:0]    prev_addr = '0;
  logic [CW-1:0]    prev_data = '0;

  function automatic logic [31:0] exp_status();
    return {exp_count, 13'd0, exp_err, exp_done, 1'b0};
  endfunction

  // Write monitor: stall stability and in-order scoreboard of accepted writes.
  always @(negedge clk) begin
    logic [AW+CW-1:0] e;
    if (prev_stall) begin
      n_checks++;
      if (fb_if.fb_write !== 1'b1 || fb_if.fb_address !== prev_addr ||
          fb_if.fb_writedata !== prev_data) begin
        n_fail++;
        $display("FAIL stall_hold: write=%b addr=%0d data=%h, required write=1 addr=%0d data=%h",
                 fb_if.fb_write, fb_if.fb_address, fb_if.fb_writedata, prev_addr, prev_data);
      end
    end
    if (reset_n && fb_if.fb_write === 1'b1 && fb_if.fb_waitrequest === 1'b0) begin
      wr_cnt++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%0d data=%h, required no write",
                 fb_if.fb_address, fb_if.fb_writedata);
      end else begin
        e = exp_q.pop_front();
        if ({fb_if.fb_address, fb_if.fb_writedata} !== e) begin
          n_fail++;
          $display("FAIL write_data: addr=%0d data=%h, required addr=%0d data=%h",
                   fb_if.fb_address, fb_if.fb_writedata, e[AW+CW-1:CW], e[CW-1:0]);
        end
      end
    end
    prev_stall = (fb_if.fb_write === 1'b1) && (fb_if.fb_waitrequest === 1'b1);
    prev_addr  = fb_if.fb_address;
    prev_data  = fb_if.fb_writedata;
  end

  task automatic send_cmd(input logic [1:0] op, input int x, input int y, input logic [7:0] c);
    @(posedge clk);
    #1;
    tog    = ~tog;
    cmd_in = {tog, 2'b00, op, 9'(y), 10'(x), c};
    if (op == 2'b11 || (op != 2'b10 && (x >= int'(HR) || y >= int'(VR)))) begin
      // rejected: no writes expected
    end else if (op == 2'b00) begin
      exp_q.push_back({AW'(y * int'(HR) + x), c});
    end else if (op == 2'b01) begin
      for (int xi = x; xi < int'(HR); xi++) exp_q.push_back({AW'(y * int'(HR) + xi), c});
    end else begin
      for (int i = 0; i < int'(FRAME); i++) exp_q.push_back({AW'(i), c});
    end
  endtask

  task automatic wait_done(input logic target, output logic ok, output int wcycles);
    ok = 1'b0;
    wcycles = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (fb_if.fb_write === 1'b1) wcycles++;
      if (status_out[1] === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cmd_in = '0;
    fb_if.fb_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (fb_if.fb_write !== 1'b0) begin
      n_fail++; $display("FAIL reset_write: got %b, required 0", fb_if.fb_write);
    end
    n_checks++;
    if (fb_if.fb_address !== '0) begin
      n_fail++; $display("FAIL reset_addr: got %0d, required 0", fb_if.fb_address);
    end
    n_checks++;
    if (fb_if.fb_writedata !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h, required 0", fb_if.fb_writedata);
    end
    n_checks++;
    if (status_out !== 32'h0) begin
      n_fail++; $display("FAIL reset_status: got %h, required 00000000", status_out);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_single_pixel();
    int busy_n = 0, wr_n = 0, wr_idx = -1, done_idx = -1;
    send_cmd(2'b00, 3, 2, 8'hE0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (status_out[0] === 1'b1) busy_n++;
      if (fb_if.fb_write === 1'b1) begin
        wr_n++;
        if (wr_idx < 0) wr_idx = i;
      end
      if (done_idx < 0 && status_out[1] !== exp_done) done_idx = i;
    end
    exp_done = ~exp_done;
    exp_count++;
    exp_err = 1'b0;
    n_checks++;
    if (busy_n != 3) begin n_fail++; $display("FAIL single_busy: got %0d cycles, required 3", busy_n); end
    n_checks++;
    if (wr_n != 1 || wr_idx != 2) begin
      n_fail++; $display("FAIL single_write: got %0d cycles at %0d, required 1 at 2", wr_n, wr_idx);
    end
    n_checks++;
    if (done_idx != 4) begin n_fail++; $display("FAIL single_done: got idx %0d, required 4", done_idx); end
    n_checks++;
    if (status_out !== 32'h0001_0002) begin
      n_fail++; $display("FAIL single_status: got %h, required 00010002", status_out);
    end
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_left: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_stall();
    logic ok, found = 1'b0;
    int wc, base = wr_cnt;
    @(posedge clk);
    #1 fb_if.fb_waitrequest = 1'b1;
    send_cmd(2'b00, 3, 2, 8'hE0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fb_if.fb_write === 1'b1) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL stall_start: got no write, required write"); end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 fb_if.fb_waitrequest = 1'b0;
    wait_done(~exp_done, ok, wc);
    exp_done = ~exp_done;
    exp_count++;
    n_checks++;
    if (!ok || wc != 1) begin
      n_fail++; $display("FAIL stall_len: got ok=%b tail=%0d, required ok=1 tail=1", ok, wc);
    end
    n_checks++;
    if (wr_cnt - base != 1) begin n_fail++; $display("FAIL stall_count: got %0d, required 1", wr_cnt - base); end
    n_checks++;
    if (status_out !== exp_status()) begin
      n_fail++; $display("FAIL stall_status: got %h, required %h", status_out, exp_status());
    end
  endtask

  task automatic test_row_edge();
    logic ok;
    int wc, base = wr_cnt;
    send_cmd(2'b01, HR - 4, VR - 1, 8'h1C);
    wait_done(~exp_done, ok, wc);
    exp_done = ~exp_done;
    exp_count++;
    n_checks++;
    if (!ok || wc != 4 || wr_cnt - base != 4) begin
      n_fail++; $display("FAIL row_edge: got ok=%b cycles=%0d writes=%0d, required 1/4/4",
                         ok, wc, wr_cnt - base);
    end
    n_checks++;
    if (status_out !== exp_status()) begin
      n_fail++; $display("FAIL row_status: got %h, required %h", status_out, exp_status());
    end
  endtask

  task automatic test_errors();
    logic [1:0] ops[3]  = '{2'b00, 2'b11, 2'b00};
    int         xs[3]   = '{HR, 0, 1};
    int         wcs[3]  = '{0, 0, 1};
    logic       errs[3] = '{1'b1, 1'b1, 1'b0};
    logic ok;
    int wc;
    for (int k = 0; k < 3; k++) begin
      send_cmd(ops[k], xs[k], 1, 8'h55);
      wait_done(~exp_done, ok, wc);
      exp_done = ~exp_done;
      exp_count++;
      exp_err = errs[k];
      n_checks++;
      if (!ok || wc != wcs[k]) begin
        n_fail++; $display("FAIL err_writes[%0d]: got ok=%b cycles=%0d, required ok=1 cycles=%0d",
                           k, ok, wc, wcs[k]);
      end
      n_checks++;
      if (status_out !== exp_status()) begin
        n_fail++; $display("FAIL err_status[%0d]: got %h, required %h", k, status_out, exp_status());
      end
    end
  endtask

  task automatic test_toggle_busy();
    logic ok1, ok2;
    int wc, base = wr_cnt;
    send_cmd(2'b10, 5, 7, 8'h03);
    repeat (10) @(posedge clk);
    send_cmd(2'b00, 0, 0, 8'hFF);
    wait_done(~exp_done, ok1, wc);
    exp_done = ~exp_done;
    wait_done(~exp_done, ok2, wc);
    exp_done = ~exp_done;
    exp_count += 16'd2;
    exp_err = 1'b0;
    n_checks++;
    if (!ok1 || !ok2 || wr_cnt - base != int'(FRAME) + 1) begin
      n_fail++; $display("FAIL toggle_busy: got ok=%b%b writes=%0d, required ok=11 writes=%0d",
                         ok1, ok2, wr_cnt - base, FRAME + 1);
    end
    n_checks++;
    if (status_out !== exp_status()) begin
      n_fail++; $display("FAIL toggle_status: got %h, required %h", status_out, exp_status());
    end
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL toggle_left: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic ok, reached = 1'b0;
    int wc, base = wr_cnt;
    send_cmd(2'b10, 0, 0, 8'h0A);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (wr_cnt - base >= 100) begin reached = 1'b1; break; end
    end
    n_checks++;
    if (!reached) begin n_fail++; $display("FAIL rst_mid_reach: got %0d writes, required 100", wr_cnt - base); end
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    // Toggle is still 1, so the clear restarts from address 0.
    exp_q.delete();
    for (int i = 0; i < int'(FRAME); i++) exp_q.push_back({AW'(i), 8'h0A});
    exp_count = '0;
    exp_done = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    n_checks++;
    if (fb_if.fb_write !== 1'b0) begin n_fail++; $display("FAIL rst_mid_write: got %b, required 0", fb_if.fb_write); end
    n_checks++;
    if (status_out !== 32'h0) begin n_fail++; $display("FAIL rst_mid_status: got %h, required 0", status_out); end
    wait_done(1'b1, ok, wc);
    exp_done = 1'b1;
    exp_count = 16'd1;
    n_checks++;
    if (!ok || status_out !== exp_status()) begin
      n_fail++; $display("FAIL rst_mid_rerun: got ok=%b status=%h, required ok=1 status=%h",
                         ok, status_out, exp_status());
    end
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_left: got %0d pending, required 0", exp_q.size()); end
  endtask

  initial begin
    fb_if.fb_waitrequest = 1'b0;
    test_reset();
    test_single_pixel();
    test_stall();
    test_row_edge();
    test_errors();
    test_toggle_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
